writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage_if.sv | 30 +++
 rtl/writeback_stage.sv | 146 ++++++++++++++
 tb/tb_writeback_stage.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// Handshake and data bundle between the memory stage, data memory and register-file write port.
interface writeback_stage_if;
    logic        MEM_valid;
    logic        MEM_ready;
    logic [4:0]  MEM_rd_sel;
    logic        MEM_rd_wr;
    logic [1:0]  MEM_wb_src;
    logic [31:0] MEM_alu_val;
    logic [31:0] MEM_pc4_val;
    logic [2:0]  MEM_funct3;
    logic [1:0]  MEM_addr_lo;
    logic        DMEM_rsp_valid;
    logic [31:0] DMEM_rsp_data;
    logic        WB_wr_en;
    logic [4:0]  WB_rd_sel;
    logic [31:0] WB_rd_val;
    logic        WB_load_err;

    modport master (
        output MEM_valid, MEM_rd_sel, MEM_rd_wr, MEM_wb_src, MEM_alu_val, MEM_pc4_val,
               MEM_funct3, MEM_addr_lo, DMEM_rsp_valid, DMEM_rsp_data,
        input  MEM_ready, WB_wr_en, WB_rd_sel, WB_rd_val, WB_load_err
    );

    modport slave (
        input  MEM_valid, MEM_rd_sel, MEM_rd_wr, MEM_wb_src, MEM_alu_val, MEM_pc4_val,
               MEM_funct3, MEM_addr_lo, DMEM_rsp_valid, DMEM_rsp_data,
        output MEM_ready, WB_wr_en, WB_rd_sel, WB_rd_val, WB_load_err
    );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: selects ALU / PC+4 / load data, waits for data memory with a timeout,
// and drives a registered register-file write port.
//
// state     | meaning
// IDLE      | ready; non-loads retire in one cycle, a load moves to WAIT_LOAD
// WAIT_LOAD | load captured, waiting for DMEM response or timeout
module writeback_stage #(
    parameter int LOAD_TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    writeback_stage_if.slave   bus
);

    localparam int CW = (LOAD_TIMEOUT_CYC > 1) ? $clog2(LOAD_TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT_CYC - 1);

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    ld_rd_q, ld_rd_d;
    logic          ld_wr_q, ld_wr_d;
    logic [2:0]    ld_f3_q, ld_f3_d;
    logic [1:0]    ld_addr_q, ld_addr_d;
    logic          wr_en_q, wr_en_d;
    logic [4:0]    rd_sel_q, rd_sel_d;
    logic [31:0]   rd_val_q, rd_val_d;
    logic          err_q, err_d;

    logic          f3_legal;
    logic [31:0]   ld_val;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    always_comb begin
        ld_byte = bus.DMEM_rsp_data[8*ld_addr_q +: 8];
        ld_half = ld_addr_q[1] ? bus.DMEM_rsp_data[31:16] : bus.DMEM_rsp_data[15:0];
        f3_legal = 1'b1;
        ld_val   = '0;
        case (ld_f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {24'h0, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_val = {16'h0, ld_half};
            3'b010:  ld_val = bus.DMEM_rsp_data;
            default: f3_legal = 1'b0;
        endcase
    end

    // Write index/data only move when the strobe fires; otherwise they hold.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_rd_d   = ld_rd_q;
        ld_wr_d   = ld_wr_q;
        ld_f3_d   = ld_f3_q;
        ld_addr_d = ld_addr_q;
        wr_en_d   = 1'b0;
        rd_sel_d  = rd_sel_q;
        rd_val_d  = rd_val_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.MEM_valid) begin
                    case (bus.MEM_wb_src)
                        2'b00: begin
                            if (bus.MEM_rd_wr && (bus.MEM_rd_sel != 5'd0)) begin
                                wr_en_d  = 1'b1;
                                rd_sel_d = bus.MEM_rd_sel;
                                rd_val_d = bus.MEM_alu_val;
                            end
                        end
                        2'b10: begin
                            if (bus.MEM_rd_wr && (bus.MEM_rd_sel != 5'd0)) begin
                                wr_en_d  = 1'b1;
                                rd_sel_d = bus.MEM_rd_sel;
                                rd_val_d = bus.MEM_pc4_val;
                            end
                        end
                        2'b01: begin
                            ld_rd_d   = bus.MEM_rd_sel;
                            ld_wr_d   = bus.MEM_rd_wr;
                            ld_f3_d   = bus.MEM_funct3;
                            ld_addr_d = bus.MEM_addr_lo;
                            cnt_d     = '0;
                            state_d   = WAIT_LOAD;
                        end
                        default: ;
                    endcase
                end
            end
            WAIT_LOAD: begin
                if (bus.DMEM_rsp_valid) begin
                    state_d = IDLE;
                    if (!f3_legal) begin
                        err_d = 1'b1;
                    end else if (ld_wr_q && (ld_rd_q != 5'd0)) begin
                        wr_en_d  = 1'b1;
                        rd_sel_d = ld_rd_q;
                        rd_val_d = ld_val;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ld_rd_q   <= '0;
            ld_wr_q   <= 1'b0;
            ld_f3_q   <= '0;
            ld_addr_q <= '0;
            wr_en_q   <= 1'b0;
            rd_sel_q  <= '0;
            rd_val_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_rd_q   <= ld_rd_d;
            ld_wr_q   <= ld_wr_d;
            ld_f3_q   <= ld_f3_d;
            ld_addr_q <= ld_addr_d;
            wr_en_q   <= wr_en_d;
            rd_sel_q  <= rd_sel_d;
            rd_val_q  <= rd_val_d;
            err_q     <= err_d;
        end
    end

    assign bus.MEM_ready   = (state_q == IDLE);
    assign bus.WB_wr_en    = wr_en_q;
    assign bus.WB_rd_sel   = rd_sel_q;
    assign bus.WB_rd_val   = rd_val_q;
    assign bus.WB_load_err = err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_writeback_stage;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    writeback_stage_if wbif ();

    writeback_stage #(.LOAD_TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wbif.slave)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          m_busy = 0;
    int          m_wait = 0;
    logic [4:0]  p_rd;
    bit          p_wr;
    logic [2:0]  p_f3;
    logic [1:0]  p_a;
    bit          e_wr, e_err;
    logic [4:0]  e_sel = '0;
    logic [31:0] e_val = '0;

    typedef struct {
        logic [1:0]  src;
        logic [4:0]  rd;
        logic        rd_wr;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [2:0]  f3;
        logic [1:0]  a;
        int          delay;
        logic [31:0] data;
        logic        x_wr;
        logic [31:0] x_val;
        logic        x_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_extract(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            3'd4:    return 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic model_step();
        e_wr  = 0;
        e_err = 0;
        if (!m_busy) begin
            if (wbif.MEM_valid) begin
                if (wbif.MEM_wb_src == 2'd1) begin
                    m_busy = 1; m_wait = 0;
                    p_rd = wbif.MEM_rd_sel; p_wr = wbif.MEM_rd_wr;
                    p_f3 = wbif.MEM_funct3; p_a  = wbif.MEM_addr_lo;
                end else if (wbif.MEM_wb_src != 2'd3 && wbif.MEM_rd_wr && wbif.MEM_rd_sel != 0) begin
                    e_wr  = 1;
                    e_sel = wbif.MEM_rd_sel;
                    e_val = (wbif.MEM_wb_src == 2'd0) ? wbif.MEM_alu_val : wbif.MEM_pc4_val;
                end
            end
        end else if (wbif.DMEM_rsp_valid) begin
            m_busy = 0;
            if (p_f3 == 3'd3 || p_f3 == 3'd6 || p_f3 == 3'd7) e_err = 1;
            else if (p_wr && p_rd != 0) begin
                e_wr  = 1;
                e_sel = p_rd;
                e_val = ref_extract(p_f3, p_a, wbif.DMEM_rsp_data);
            end
        end else begin
            m_wait++;
            if (m_wait == TO) begin
                m_busy = 0;
                e_err  = 1;
            end
        end
    endtask

    task automatic tick(input string tag);
        chk({tag, "_ready"}, 32'(wbif.MEM_ready), 32'(!m_busy));
        model_step();
        @(posedge clk);
        #1;
        chk({tag, "_wr"}, 32'(wbif.WB_wr_en), 32'(e_wr));
        chk({tag, "_err"}, 32'(wbif.WB_load_err), 32'(e_err));
        if (e_wr) begin
            chk({tag, "_sel"}, 32'(wbif.WB_rd_sel), 32'(e_sel));
            chk({tag, "_val"}, wbif.WB_rd_val, e_val);
        end
    endtask

    task automatic drive_quiet();
        wbif.MEM_valid      = 0;
        wbif.DMEM_rsp_valid = 0;
    endtask

    task automatic drive_op(input logic [1:0] src, input logic [4:0] rd, input logic rd_wr,
                            input logic [31:0] alu, input logic [31:0] pc4,
                            input logic [2:0] f3, input logic [1:0] a);
        wbif.MEM_valid   = 1;
        wbif.MEM_wb_src  = src;
        wbif.MEM_rd_sel  = rd;
        wbif.MEM_rd_wr   = rd_wr;
        wbif.MEM_alu_val = alu;
        wbif.MEM_pc4_val = pc4;
        wbif.MEM_funct3  = f3;
        wbif.MEM_addr_lo = a;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_z_wr"}, 32'(wbif.WB_wr_en), 0);
        chk({tag, "_z_sel"}, 32'(wbif.WB_rd_sel), 0);
        chk({tag, "_z_val"}, wbif.WB_rd_val, 0);
        chk({tag, "_z_err"}, 32'(wbif.WB_load_err), 0);
        chk({tag, "_z_ready"}, 32'(wbif.MEM_ready), 1);
    endtask

    task automatic model_reset();
        m_busy = 0; m_wait = 0;
        e_sel = '0; e_val = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, first_at, wrs;
        drive_quiet();
        drive_op(2'd0, 5'd0, 1'b0, 32'h0, 32'h0, 3'd0, 2'd0);
        wbif.MEM_valid     = 0;
        wbif.DMEM_rsp_data = 32'h0;
        #12;
        check_zero_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();

        vecs.push_back('{2'd0, 5'd5,  1, 32'h1234, 32'h0, 3'd0, 2'd0, 0, 32'h0, 1, 32'h00001234, 0});
        vecs.push_back('{2'd0, 5'd0,  1, 32'h5555, 32'h0, 3'd0, 2'd0, 0, 32'h0, 0, 32'h0, 0});
        vecs.push_back('{2'd2, 5'd31, 1, 32'h1, 32'h80000004, 3'd0, 2'd0, 0, 32'h0, 1, 32'h80000004, 0});
        vecs.push_back('{2'd1, 5'd3,  1, 32'h0, 32'h0, 3'd0, 2'd2, 2, 32'h11802233, 1, 32'hFFFFFF80, 0});
        vecs.push_back('{2'd1, 5'd4,  1, 32'h0, 32'h0, 3'd4, 2'd2, 2, 32'h11802233, 1, 32'h00000080, 0});
        vecs.push_back('{2'd1, 5'd6,  1, 32'h0, 32'h0, 3'd5, 2'd2, 2, 32'h11802233, 1, 32'h00001180, 0});
        vecs.push_back('{2'd1, 5'd7,  1, 32'h0, 32'h0, 3'd1, 2'd0, 0, 32'h0000F00D, 1, 32'hFFFFF00D, 0});
        vecs.push_back('{2'd1, 5'd8,  1, 32'h0, 32'h0, 3'd2, 2'd3, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0});
        vecs.push_back('{2'd1, 5'd9,  1, 32'h0, 32'h0, 3'd0, 2'd0, 0, 32'h1180227F, 1, 32'h0000007F, 0});
        vecs.push_back('{2'd1, 5'd10, 1, 32'h0, 32'h0, 3'd0, 2'd3, 0, 32'h11802233, 1, 32'h00000011, 0});
        vecs.push_back('{2'd1, 5'd11, 1, 32'h0, 32'h0, 3'd3, 2'd0, 1, 32'h12345678, 0, 32'h0, 1});
        vecs.push_back('{2'd3, 5'd12, 1, 32'h99, 32'h0, 3'd0, 2'd0, 0, 32'h0, 0, 32'h0, 0});
        vecs.push_back('{2'd1, 5'd13, 0, 32'h0, 32'h0, 3'd2, 2'd0, 0, 32'hAAAA5555, 0, 32'h0, 0});

        foreach (vecs[i]) begin
            drive_op(vecs[i].src, vecs[i].rd, vecs[i].rd_wr, vecs[i].alu, vecs[i].pc4,
                     vecs[i].f3, vecs[i].a);
            tick($sformatf("v%0d_acc", i));
            wbif.MEM_valid = 0;
            if (vecs[i].src == 2'd1) begin
                for (int d = 0; d < vecs[i].delay; d++) begin
                    chk($sformatf("v%0d_busy", i), 32'(wbif.MEM_ready), 0);
                    tick($sformatf("v%0d_wait", i));
                end
                wbif.DMEM_rsp_valid = 1;
                wbif.DMEM_rsp_data  = vecs[i].data;
                tick($sformatf("v%0d_rsp", i));
                wbif.DMEM_rsp_valid = 0;
            end
            chk($sformatf("v%0d_tbl_wr", i), 32'(wbif.WB_wr_en), 32'(vecs[i].x_wr));
            chk($sformatf("v%0d_tbl_err", i), 32'(wbif.WB_load_err), 32'(vecs[i].x_err));
            if (vecs[i].x_wr) begin
                chk($sformatf("v%0d_tbl_sel", i), 32'(wbif.WB_rd_sel), 32'(vecs[i].rd));
                chk($sformatf("v%0d_tbl_val", i), wbif.WB_rd_val, vecs[i].x_val);
            end
            tick($sformatf("v%0d_after", i));
        end

        // back-to-back non-loads
        for (int k = 1; k <= 4; k++) begin
            drive_op(2'd0, 5'(k), 1'b1, 32'h100 + 32'(k), 32'h0, 3'd0, 2'd0);
            tick("b2b");
        end
        drive_quiet();
        tick("b2b_end");

        // timeout with no response
        drive_op(2'd1, 5'd14, 1'b1, 32'h0, 32'h0, 3'd2, 2'd0);
        tick("to_acc");
        drive_quiet();
        pulses = 0; first_at = 0; wrs = 0;
        for (int c = 1; c <= TO + 2; c++) begin
            tick("to_wait");
            if (wbif.WB_load_err) begin
                pulses++;
                if (first_at == 0) first_at = c;
            end
            if (wbif.WB_wr_en) wrs++;
        end
        chk("to_pulses", 32'(pulses), 1);
        chk("to_when", 32'(first_at), TO);
        chk("to_no_write", 32'(wrs), 0);
        chk("to_ready", 32'(wbif.MEM_ready), 1);

        // response in the final allowed cycle wins over the timeout
        drive_op(2'd1, 5'd15, 1'b1, 32'h0, 32'h0, 3'd2, 2'd0);
        tick("last_acc");
        drive_quiet();
        for (int c = 1; c < TO; c++) tick("last_wait");
        wbif.DMEM_rsp_valid = 1;
        wbif.DMEM_rsp_data  = 32'hCAFEF00D;
        tick("last_rsp");
        drive_quiet();
        chk("last_wr", 32'(wbif.WB_wr_en), 1);
        chk("last_err", 32'(wbif.WB_load_err), 0);
        chk("last_val", wbif.WB_rd_val, 32'hCAFEF00D);
        tick("last_after");

        // reset during WAIT_LOAD, response after release is ignored
        drive_op(2'd1, 5'd16, 1'b1, 32'h0, 32'h0, 3'd2, 2'd0);
        tick("rst_acc");
        drive_quiet();
        tick("rst_wait");
        rst_n = 0;
        model_reset();
        #1;
        check_zero_outputs("rst_async");
        @(posedge clk); #1;
        rst_n = 1;
        wbif.DMEM_rsp_valid = 1;
        wbif.DMEM_rsp_data  = 32'h0BADF00D;
        tick("rst_rsp");
        drive_quiet();
        check_zero_outputs("rst_after");

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int rsp_pct;
            rsp_pct = ((n / 500) % 2 == 0) ? 40 : 4;
            wbif.MEM_valid   = ($urandom_range(0, 99) < 60);
            wbif.MEM_wb_src  = 2'($urandom_range(0, 3));
            wbif.MEM_rd_sel  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wbif.MEM_rd_wr   = ($urandom_range(0, 7) != 0);
            wbif.MEM_alu_val = $urandom;
            wbif.MEM_pc4_val = $urandom;
            wbif.MEM_funct3  = 3'($urandom_range(0, 7));
            wbif.MEM_addr_lo = 2'($urandom_range(0, 3));
            wbif.DMEM_rsp_valid = ($urandom_range(0, 99) < rsp_pct);
            wbif.DMEM_rsp_data  = $urandom;
            tick("rnd");
        end
        drive_quiet();
        tick("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
